ad7528_serial_writer: RTL and testbench

- Host-side transmitter for the serial attenuation-DAC programming link: datadac, clkdac, csdac1n, csdac2n.
- Takes one write request (channel, A/B select, 8-bit factor) over valid/ready and serializes it MSB-first into the 74HC164-style shift register on the far side.
- Then presents the A/B select on datadac and pulses the channel's chip-select low.
- Sits wherever the design must program the dual AD7528 attenuators: the system-controller model, or a bench driver for the attenuation block.

---
 rtl/ad7528_pkg.sv | 30 +++
 rtl/ad7528_phase_timer.sv | 38 +++
 rtl/ad7528_serial_writer.sv | 196 +++++++++++++++++++
 tb/tb_ad7528_serial_writer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ad7528_pkg.sv
// ad7528_pkg
//   Shared types and constants for the AD7528 serial attenuation-DAC writer.
//   writer_state_t : transfer FSM states
//   CHAN_* / SEL_* : encodings of the request channel and A/B select bits
//   write_req_t    : latched copy of one write request
package ad7528_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_LO,
        SHIFT_HI,
        SELECT,
        STROBE,
        RECOVER
    } writer_state_t;

    localparam logic CHAN_LEFT  = 1'b0;
    localparam logic CHAN_RIGHT = 1'b1;
    localparam logic SEL_A      = 1'b1;
    localparam logic SEL_B      = 1'b0;

    localparam int AD7528_BITS = 8;

    typedef struct packed {
        logic                   chan;
        logic                   sel;
        logic [AD7528_BITS-1:0] data;
    } write_req_t;

endpackage

// File: rtl/ad7528_phase_timer.sv
// ad7528_phase_timer
//   Loadable 8-bit down-counter used to time every phase of a transfer.
//   Loading N makes expire pulse during the N-th cycle after the load edge;
//   penult pulses the cycle before that, which lets the FSM register outputs
//   that must be valid during a phase's final cycle.
// Ports:
//   clk, reset_n : clock, synchronous active-low reset
//   load         : load load_val (takes priority over counting)
//   load_val     : phase length in clk cycles (>= 2)
//   expire       : last cycle of the phase
//   penult       : second-to-last cycle of the phase
module ad7528_phase_timer (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic       expire,
    output logic       penult
);

    logic [7:0] cnt;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
        end
    end

    // Phases are never shorter than two cycles, so a count of 1 is only
    // present for a single cycle and these are clean one-cycle pulses.
    assign expire = (cnt == 8'd1);
    assign penult = (cnt == 8'd2);

endmodule

// File: rtl/ad7528_serial_writer.sv
// ad7528_serial_writer
//   Serializes one attenuation write (channel, A/B select, 8-bit factor)
//   MSB-first into the far-side shift register, then drives the A/B select
//   on datadac and pulses the chosen chip-select low.
//   Optional feature macro: AD7528_SHADOW_EN adds readback registers of the
//   last factor written to each of the four DAC latches.
// Parameters:
//   CLK_DIV : clk cycles per clkdac half-period / datadac setup (2..255)
//   CS_HOLD : clk cycles the chip-select is held low (2..255)
// Ports:
//   clk, reset_n           : clock, synchronous active-low reset
//   req_valid / req_ready  : request handshake
//   req_chan, req_sel      : target DAC (0 = left) and latch (1 = A)
//   req_data               : attenuation factor
//   done                   : one-cycle completion pulse
//   datadac, clkdac        : serial data and shift clock
//   csdac1n, csdac2n       : left / right latch strobes, active low
//   shadow_*               : (AD7528_SHADOW_EN) programmed-factor readback
module ad7528_serial_writer
    import ad7528_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned CS_HOLD = 3
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_chan,
    input  logic                   req_sel,
    input  logic [AD7528_BITS-1:0] req_data,
    output logic                   done,
    output logic                   datadac,
    output logic                   clkdac,
    output logic                   csdac1n,
`ifdef AD7528_SHADOW_EN
    output logic                   csdac2n,
    output logic [AD7528_BITS-1:0] shadow_left_a,
    output logic [AD7528_BITS-1:0] shadow_left_b,
    output logic [AD7528_BITS-1:0] shadow_right_a,
    output logic [AD7528_BITS-1:0] shadow_right_b
`else
    output logic                   csdac2n
`endif
);

    localparam logic [7:0] DIV_CYC  = 8'(CLK_DIV);
    localparam logic [7:0] HOLD_CYC = 8'(CS_HOLD);

    writer_state_t          state;
    write_req_t             req_q;
    logic [AD7528_BITS-1:0] shift_q;
    logic [2:0]             bit_cnt;

    logic       accept;
    logic       tmr_load;
    logic [7:0] tmr_val;
    logic       expire;
    logic       penult;

    // req_ready is high in IDLE and in the final RECOVER cycle, so a held
    // request is taken on the done cycle with no idle gap.
    assign accept = req_valid && req_ready;

    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = DIV_CYC;
        if (accept) begin
            tmr_load = 1'b1;
        end else if (expire) begin
            case (state)
                SHIFT_LO, SHIFT_HI, STROBE: tmr_load = 1'b1;
                SELECT: begin
                    tmr_load = 1'b1;
                    tmr_val  = HOLD_CYC;
                end
                default: ;
            endcase
        end
    end

    ad7528_phase_timer u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expire   (expire),
        .penult   (penult)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            req_q     <= '0;
            shift_q   <= '0;
            bit_cnt   <= '0;
            req_ready <= 1'b1;
            done      <= 1'b0;
            datadac   <= 1'b0;
            clkdac    <= 1'b0;
            csdac1n   <= 1'b1;
            csdac2n   <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: ;
                SHIFT_LO: begin
                    if (expire) begin
                        state  <= SHIFT_HI;
                        clkdac <= 1'b1;
                    end
                end
                SHIFT_HI: begin
                    if (expire) begin
                        clkdac <= 1'b0;
                        if (bit_cnt == 3'(AD7528_BITS - 1)) begin
                            state   <= SELECT;
                            datadac <= req_q.sel;
                        end else begin
                            // datadac only moves together with the falling
                            // clkdac, so it is stable for the whole high phase.
                            state   <= SHIFT_LO;
                            bit_cnt <= bit_cnt + 3'd1;
                            datadac <= shift_q[AD7528_BITS-1];
                            shift_q <= shift_q << 1;
                        end
                    end
                end
                SELECT: begin
                    if (expire) begin
                        state <= STROBE;
                        if (req_q.chan == CHAN_RIGHT) csdac2n <= 1'b0;
                        else                          csdac1n <= 1'b0;
                    end
                end
                STROBE: begin
                    if (expire) begin
                        state   <= RECOVER;
                        csdac1n <= 1'b1;
                        csdac2n <= 1'b1;
                    end
                end
                RECOVER: begin
                    // Raise done/ready one cycle early so both are registered
                    // and visible during the final RECOVER cycle.
                    if (penult) begin
                        done      <= 1'b1;
                        req_ready <= 1'b1;
                    end
                    if (expire) begin
                        state   <= IDLE;
                        datadac <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase

            // Acceptance overrides the RECOVER exit for back-to-back writes.
            if (accept) begin
                state     <= SHIFT_LO;
                req_q     <= '{chan: req_chan, sel: req_sel, data: req_data};
                datadac   <= req_data[AD7528_BITS-1];
                shift_q   <= req_data << 1;
                bit_cnt   <= '0;
                clkdac    <= 1'b0;
                req_ready <= 1'b0;
            end
        end
    end

`ifdef AD7528_SHADOW_EN
    // Index is {chan, sel}: 0 = left B, 1 = left A, 2 = right B, 3 = right A.
    logic [3:0][AD7528_BITS-1:0] shadow_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            shadow_q <= '0;
        end else if (state == RECOVER && penult) begin
            shadow_q[{req_q.chan, req_q.sel}] <= req_q.data;
        end
    end

    assign shadow_left_b  = shadow_q[0];
    assign shadow_left_a  = shadow_q[1];
    assign shadow_right_b = shadow_q[2];
    assign shadow_right_a = shadow_q[3];
`endif

    always_ff @(posedge clk) begin
        if (reset_n) begin
            assert (CLK_DIV >= 2 && CLK_DIV <= 255 && CS_HOLD >= 2 && CS_HOLD <= 255)
            else $error("ad7528_serial_writer: CLK_DIV and CS_HOLD must be in 2..255");
        end
    end

endmodule

// File: tb/tb_ad7528_serial_writer.sv
module tb_ad7528_serial_writer;
    import ad7528_pkg::*;

    localparam int CLK_DIV = 2;
    localparam int CS_HOLD = 3;
    localparam int LAT     = 39;   // 18*2 + 3

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_chan = 1'b0;
    logic       req_sel = 1'b0;
    logic [7:0] req_data = 8'h00;
    logic       req_ready, done, datadac, clkdac, csdac1n, csdac2n;
`ifdef AD7528_SHADOW_EN
    logic [7:0] shadow_left_a, shadow_left_b, shadow_right_a, shadow_right_b;
`endif

    always #5 clk = ~clk;

    ad7528_serial_writer #(.CLK_DIV(CLK_DIV), .CS_HOLD(CS_HOLD)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_chan  (req_chan),
        .req_sel   (req_sel),
        .req_data  (req_data),
        .done      (done),
        .datadac   (datadac),
        .clkdac    (clkdac),
        .csdac1n   (csdac1n),
`ifdef AD7528_SHADOW_EN
        .csdac2n        (csdac2n),
        .shadow_left_a  (shadow_left_a),
        .shadow_left_b  (shadow_left_b),
        .shadow_right_a (shadow_right_a),
        .shadow_right_b (shadow_right_b)
`else
        .csdac2n   (csdac2n)
`endif
    );

    typedef struct {
        logic       chan;
        logic       sel;
        logic [7:0] byte_v;
    } exp_t;

    exp_t exp_q[$];
    int   acc_q[$];
    int   done_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, expv, expv, cyc);
        end
    endtask

    // ---------------- receiver model + scoreboard monitor ----------------
    logic       p_clk = 1'b0, p_cs1 = 1'b1, p_cs2 = 1'b1, p_dat = 1'b0;
    logic [7:0] sh = 8'h00;
    int         rises = 0, falls1 = 0, falls2 = 0, low_cnt = 0;
    int         rises_total = 0, cs_fall_tot = 0;
    logic       latch_sel = 1'b0;
    bit         sel_unstable = 0, clkhi_change = 0, cs_overlap = 0;
    logic [7:0] rx [2][2];   // [chan][sel] factors latched by the far side

    initial begin
        for (int c = 0; c < 2; c++)
            for (int s = 0; s < 2; s++) rx[c][s] = 8'h00;
    end

    always @(negedge clk) begin
        exp_t e;
        int   t0;
        if (!reset_n) begin
            sh = 8'h00; rises = 0; falls1 = 0; falls2 = 0; low_cnt = 0;
            sel_unstable = 0; clkhi_change = 0;
        end else begin
            if (clkdac && !p_clk) begin
                sh = {sh[6:0], datadac};
                rises++;
                rises_total++;
            end
            if (clkdac && p_clk && datadac != p_dat) clkhi_change = 1;
            if (!csdac1n && !csdac2n) cs_overlap = 1;
            if (!csdac1n && p_cs1) begin falls1++; cs_fall_tot++; end
            if (!csdac2n && p_cs2) begin falls2++; cs_fall_tot++; end
            if (!csdac1n || !csdac2n) begin
                if (low_cnt == 0) latch_sel = datadac;
                else if (datadac != latch_sel) sel_unstable = 1;
                low_cnt++;
            end
            if (csdac1n && !p_cs1) rx[0][datadac] = sh;
            if (csdac2n && !p_cs2) rx[1][datadac] = sh;
            if (done) begin
                done_q.push_back(cyc);
                if (exp_q.size() == 0 || acc_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e  = exp_q.pop_front();
                    t0 = acc_q.pop_front();
                    chk("clkdac_rises", rises, 8);
                    chk("shifted_byte", int'(sh), int'(e.byte_v));
                    chk("cs1_falls", falls1, e.chan ? 0 : 1);
                    chk("cs2_falls", falls2, e.chan ? 1 : 0);
                    chk("cs_low_cycles", low_cnt, CS_HOLD);
                    chk("strobe_sel", int'(latch_sel), int'(e.sel));
                    chk("strobe_sel_stable", int'(sel_unstable), 0);
                    chk("data_change_clk_high", int'(clkhi_change), 0);
                    chk("done_latency", cyc - t0, LAT);
                end
                sh = 8'h00; rises = 0; falls1 = 0; falls2 = 0; low_cnt = 0;
                sel_unstable = 0; clkhi_change = 0;
            end
        end
        p_clk = clkdac; p_cs1 = csdac1n; p_cs2 = csdac2n; p_dat = datadac;
    end

    // ---------------- stimulus ----------------
    // Called just after a posedge. track=0 issues a request with no expected
    // completion (used for the abandoned transfer).
    task automatic send(input logic ch, input logic s, input logic [7:0] d,
                        input bit track, input bit hold);
        int n = 0;
        req_chan = ch; req_sel = s; req_data = d; req_valid = 1'b1;
        if (track) exp_q.push_back('{chan: ch, sel: s, byte_v: d});
        @(negedge clk);
        while (!req_ready && n < 200) begin @(negedge clk); n++; end
        if (!req_ready) begin
            chk("accept_timeout", 0, 1);
            req_valid = 1'b0;
            return;
        end
        if (track) acc_q.push_back(cyc);
        @(posedge clk); #1;
        if (!hold) begin
            // Scribble on the inputs: the latched request must be unaffected.
            req_valid = 1'b0; req_chan = ~ch; req_sel = ~s; req_data = ~d;
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin @(posedge clk); n++; end
        chk("drain_timeout", exp_q.size(), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_datadac"}, int'(datadac), 0);
        chk({tag, "_clkdac"}, int'(clkdac), 0);
        chk({tag, "_csdac1n"}, int'(csdac1n), 1);
        chk({tag, "_csdac2n"}, int'(csdac2n), 1);
        chk({tag, "_req_ready"}, int'(req_ready), 1);
        chk({tag, "_done"}, int'(done), 0);
    endtask

    initial begin
        int n;
        int falls_base, dones_base;

        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk_reset_outputs("idle");

        // Left DAC, latch A, 0xA5: bit stream 1,0,1,0,0,1,0,1
        send(CHAN_LEFT, SEL_A, 8'hA5, 1, 0);
        wait_drain();

        // Right DAC, latch B, 0xFF: receiver factor scales to 255*9/16
        send(CHAN_RIGHT, SEL_B, 8'hFF, 1, 0);
        wait_drain();
        chk("rx_right_b_raw", int'(rx[1][0]), 8'hFF);
        chk("rx_right_b_scaled", (int'(rx[1][0]) * 9) / 16, 8'h8F);
        chk("rx_left_a_kept", int'(rx[0][1]), 8'hA5);
        chk("rx_left_b_kept", int'(rx[0][0]), 8'h00);
        chk("rx_right_a_kept", int'(rx[1][1]), 8'h00);

        // Back-to-back with req_valid held high
        done_q.delete();
        send(CHAN_LEFT, SEL_B, 8'h01, 1, 1);
        send(CHAN_RIGHT, SEL_A, 8'h80, 1, 0);
        wait_drain();
        chk("b2b_done_count", done_q.size(), 2);
        if (done_q.size() == 2) chk("b2b_done_spacing", done_q[1] - done_q[0], LAT);
        chk("cs_overlap", int'(cs_overlap), 0);
        chk("rx_left_b_b2b", int'(rx[0][0]), 8'h01);
        chk("rx_right_a_b2b", int'(rx[1][1]), 8'h80);

        // Reset during SHIFT_HI of bit 4 (fifth clkdac rise)
        falls_base = cs_fall_tot;
        dones_base = done_q.size();
        n = rises_total;
        send(CHAN_RIGHT, SEL_A, 8'hC3, 0, 0);
        begin
            int k = 0;
            while (rises_total < n + 5 && k < 200) begin @(negedge clk); k++; end
            chk("midreset_reach_bit4", rises_total - n, 5);
        end
        #1 reset_n = 1'b0;
        @(posedge clk); #1;
        chk_reset_outputs("midreset");
        @(negedge clk); #1 reset_n = 1'b1;
        repeat (60) @(posedge clk);
        #1;
        chk("midreset_no_cs", cs_fall_tot - falls_base, 0);
        chk("midreset_no_done", done_q.size() - dones_base, 0);
        chk("midreset_rx_right_a", int'(rx[1][1]), 8'h80);

        send(CHAN_RIGHT, SEL_A, 8'h3C, 1, 0);
        wait_drain();
        chk("after_reset_rx_right_a", int'(rx[1][1]), 8'h3C);

`ifdef AD7528_SHADOW_EN
        send(CHAN_LEFT, SEL_A, 8'h10, 1, 0);
        wait_drain();
        chk("shadow_left_a", int'(shadow_left_a), 8'h10);
        send(CHAN_LEFT, SEL_B, 8'h20, 1, 0);
        wait_drain();
        chk("shadow_left_b", int'(shadow_left_b), 8'h20);
        send(CHAN_RIGHT, SEL_A, 8'h30, 1, 0);
        wait_drain();
        chk("shadow_right_a", int'(shadow_right_a), 8'h30);
        send(CHAN_RIGHT, SEL_B, 8'h40, 1, 0);
        wait_drain();
        chk("shadow_right_b", int'(shadow_right_b), 8'h40);
        chk("shadow_left_a_kept", int'(shadow_left_a), 8'h10);
        chk("shadow_left_b_kept", int'(shadow_left_b), 8'h20);
        chk("shadow_right_a_kept", int'(shadow_right_a), 8'h30);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
